// File: rtl/bcd_conv_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// default sizes, display blank code, FSM encoding and the BCD range limit.
package bcd_conv_seq_pkg;

  localparam int unsigned WIDTH_DEF  = 24;
  localparam int unsigned DIGITS_DEF = 6;

  // Nibble code the 7-segment driver renders as a blank digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    StIdle = 1'b0,
    StConv = 1'b1
  } state_e;

  // Largest magnitude representable in the given number of BCD digits (10^digits - 1).
  function automatic logic [63:0] bcd_max(input int unsigned digits);
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] BCD_MAX_DEF = bcd_max(DIGITS_DEF);

endpackage

// File: rtl/bcd_conv_seq_digit_adj.sv
// Double-dabble correction cell: add 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) begin
      nib_o = nib_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_conv_seq.sv
// Multi-cycle binary-to-BCD converter: sign/magnitude split on accept, then one
// double-dabble shift per clock, publishing packed BCD plus sign/overflow flags.
module bcd_conv_seq
  import bcd_conv_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out,
  output logic                  ovf_out
);

  localparam int unsigned AccW = 4 * DIGITS;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [63:0] MaxMag = bcd_max(DIGITS);

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic [AccW-1:0]  bcd_out_q, bcd_out_d;
  logic             neg_out_q, neg_out_d;
  logic             ovf_out_q, ovf_out_d;
  logic             valid_q, valid_d;

  logic             in_neg;
  logic [WIDTH-1:0] in_mag;
  logic             in_ovf;
  logic [AccW-1:0]  acc_adj;
  logic [AccW-1:0]  acc_shift;
  logic             last_step;
  logic             unused_acc_msb;

  // Sign/magnitude of the incoming operand; the most negative value still fits unsigned.
  always_comb begin
    in_neg = SIGNED && bin_in[WIDTH-1];
    in_mag = in_neg ? (~bin_in + WIDTH'(1)) : bin_in;
    in_ovf = (64'(in_mag) > MaxMag);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (acc_q[4*g +: 4]),
      .nib_o (acc_adj[4*g +: 4])
    );
  end

  // The digit shifted out of the top only matters when ovf already blanks the result.
  assign acc_shift      = {acc_adj[AccW-2:0], bin_q[WIDTH-1]};
  assign unused_acc_msb = acc_adj[AccW-1];
  assign last_step      = (cnt_q == '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)     state_d = StConv;
      StConv: if (last_step) state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == StIdle);
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    bcd_out_d = bcd_out_q;
    neg_out_d = neg_out_q;
    ovf_out_d = ovf_out_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d = in_mag;
          acc_d = '0;
          cnt_d = CntW'(WIDTH - 1);
          neg_d = in_neg;
          ovf_d = in_ovf;
        end
      end
      StConv: begin
        acc_d = acc_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (last_step) begin
          cnt_d     = '0;
          bcd_out_d = ovf_q ? {DIGITS{BCD_BLANK}} : acc_shift;
          neg_out_d = neg_q;
          ovf_out_d = ovf_q;
          valid_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bin_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_out_q <= '0;
      neg_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      bcd_out_q <= bcd_out_d;
      neg_out_q <= neg_out_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
    end
  end

  assign valid   = valid_q;
  assign bcd_out = bcd_out_q;
  assign neg_out = neg_out_q;
  assign ovf_out = ovf_out_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq: reset, signed/overflow cases, busy rejection,
// back-to-back acceptance, mid-conversion reset and output hold.
module tb_bcd_conv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] bin_in;
  logic        ready;
  logic        valid;
  logic [23:0] bcd_out;
  logic        neg_out;
  logic        ovf_out;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_conv_seq #(
    .WIDTH  (24),
    .DIGITS (6),
    .SIGNED (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .ready   (ready),
    .valid   (valid),
    .bcd_out (bcd_out),
    .neg_out (neg_out),
    .ovf_out (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operand for one edge; returns at the negedge after the accept edge.
  task automatic accept(input logic [23:0] v);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    check("ready_drop", 32'(ready), 32'd0);
  endtask

  // Counts negedges until valid is seen; budget+1 means it never came.
  task automatic wait_valid(input int budget, output int lat);
    lat = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [23:0] v, input logic [23:0] exp_bcd,
                     input logic exp_neg, input logic exp_ovf);
    int lat;
    accept(v);
    wait_valid(40, lat);
    check({tag, "_lat"}, 32'(lat), 32'd24);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    check({tag, "_neg"}, 32'(neg_out), 32'(exp_neg));
    check({tag, "_ovf"}, 32'(ovf_out), 32'(exp_ovf));
    check({tag, "_rdy"}, 32'(ready), 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int lat;
    int hits;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 24'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_neg", 32'(neg_out), 32'd0);
    check("rst_ovf", 32'(ovf_out), 32'd0);

    run("pos", 24'd123456, 24'h123456, 1'b0, 1'b0);
    run("neg42", 24'hFFFFD6, 24'h000042, 1'b1, 1'b0);
    run("minneg", 24'h800000, 24'hFFFFFF, 1'b1, 1'b1);
    run("max", 24'd999999, 24'h999999, 1'b0, 1'b0);
    run("ovf", 24'd1000000, 24'hFFFFFF, 1'b0, 1'b1);

    // Start while busy must be dropped; start in the valid cycle must be taken.
    accept(24'd7);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 24'd555;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 24'hABCDEF;
    wait_valid(40, lat);
    check("busy_lat", 32'(lat), 32'd19);
    check("busy_bcd", 32'(bcd_out), 32'h000007);
    start  = 1'b1;
    bin_in = 24'd555;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 24'd0;
    if (valid) lat = 1;
    else begin
      wait_valid(40, lat);
      lat = lat + 1;
    end
    check("b2b_lat", 32'(lat), 32'd25);
    check("b2b_bcd", 32'(bcd_out), 32'h000555);

    // Reset mid-conversion aborts silently and clears the outputs.
    @(negedge clk);
    accept(24'd123456);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_neg", 32'(neg_out), 32'd0);
    check("abort_ovf", 32'(ovf_out), 32'd0);
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (valid) hits++;
    end
    check("abort_novalid", 32'(hits), 32'd0);
    run("zero", 24'd0, 24'h000000, 1'b0, 1'b0);

    // Outputs hold while idle regardless of bin_in.
    run("hold", 24'd321, 24'h000321, 1'b0, 1'b0);
    hits = 0;
    for (int k = 0; k < 50; k++) begin
      bin_in = 24'($urandom);
      @(negedge clk);
      if (valid || bcd_out !== 24'h000321) hits++;
    end
    check("hold_stable", 32'(hits), 32'd0);
    check("hold_bcd", 32'(bcd_out), 32'h000321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
